// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII frame receiver.
// Holds the receive FSM encoding and the CRC-32 constants.
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wise reflected CRC-32 next-state function.
// Bits are consumed LSB first, as they arrive on the wire.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] POLY_R = bitrev32(CRC_POLY);

    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (crc_o[0] ^ data_i[i]) begin
                crc_o = (crc_o >> 1) ^ POLY_R;
            end else begin
                crc_o = crc_o >> 1;
            end
        end
    end

endmodule

// File: rtl/gmii_frame_rx.sv
// GMII receive framer: strips preamble/SFD and FCS, checks CRC,
// length and rx_er, and flags each frame good or bad on its last beat.
module gmii_frame_rx
    import gmii_rx_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        out_good,
    output logic        out_bad,
    output logic [15:0] frame_count,
    output logic [15:0] err_count
);

    localparam int CW = $clog2(MAX_FRAME + 2);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     crc_q, crc_d, crc_nx;
    logic [4:0][7:0] dl_q, dl_d;
    logic            err_q, err_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            good_q, good_d;
    logic            bad_q, bad_d;
    logic [15:0]     fcnt_q, fcnt_d;
    logic [15:0]     ecnt_q, ecnt_d;
    logic            runt;
    logic            frame_ok;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (gmii_rxd),
        .crc_o  (crc_nx)
    );

    assign frame_ok = (bitrev32(crc_q) == CRC_RESIDUE) && !err_q
                   && (cnt_q >= CW'(MIN_FRAME))
                   && (cnt_q <= CW'(MAX_FRAME));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        dl_d    = dl_q;
        err_d   = err_q;
        data_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        fcnt_d  = fcnt_q;
        ecnt_d  = ecnt_q;
        runt    = 1'b0;

        unique case (state_q)
            S_IDLE, S_PREAMBLE: begin
                cnt_d = '0;
                crc_d = CRC_INIT;
                dl_d  = '0;
                err_d = 1'b0;
                if (!gmii_rx_dv) begin
                    state_d = S_IDLE;
                end else begin
                    unique case (1'b1)
                        gmii_rxd == PREAMBLE_BYTE: state_d = S_PREAMBLE;
                        gmii_rxd == SFD_BYTE:      state_d = S_DATA;
                        default:                   state_d = S_DROP;
                    endcase
                end
            end
            S_DATA: begin
                if (!gmii_rx_dv) begin
                    state_d = S_IDLE;
                    if (cnt_q >= CW'(5)) begin
                        data_d  = dl_q[4];
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        good_d  = frame_ok;
                        bad_d   = !frame_ok;
                    end else begin
                        runt = 1'b1;
                    end
                end else begin
                    crc_d = crc_nx;
                    dl_d  = {dl_q[3:0], gmii_rxd};
                    cnt_d = cnt_q + CW'(1);
                    if (gmii_rx_er) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q >= CW'(5)) begin
                        data_d  = dl_q[4];
                        valid_d = 1'b1;
                    end
                    // Oversize: close the frame now, drop the rest
                    if (cnt_q == CW'(MAX_FRAME)) begin
                        last_d  = 1'b1;
                        bad_d   = 1'b1;
                        state_d = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (!gmii_rx_dv) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (good_d && fcnt_q != 16'hFFFF) begin
            fcnt_d = fcnt_q + 16'd1;
        end
        if ((bad_d || runt) && ecnt_q != 16'hFFFF) begin
            ecnt_d = ecnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            crc_q   <= CRC_INIT;
            dl_q    <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            fcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            dl_q    <= dl_d;
            err_q   <= err_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            fcnt_q  <= fcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign out_good    = good_q;
    assign out_bad     = bad_q;
    assign frame_count = fcnt_q;
    assign err_count   = ecnt_q;

endmodule
